v810_sysreg: RTL
================

# v810_sysreg

System register file and exception sequencer for the V810 core. Holds EIPC, EIPSW, FEPC, FEPSW, ECR, PSW, CHCW and ADTRE, and serves LDSR/STSR through the `sr_sel_t` select code. It accepts exceptions, NMI, maskable interrupts and RETI from the execute stage. It then hands the fetch stage a redirect PC through a valid/ack handshake. Sits beside execute; consumes the `v810_pkg` types and feeds fetch.

## Interface
- PIR_VALUE, 32'h0000_8100, constant returned on STSR PIR
- TKCW_VALUE, 32'h0000_00E0, constant returned on STSR TKCW
- CLK  in  1  core clock
- RES  in  1  asynchronous reset, active-high
- CE  in  1  clock enable; all state advances only when CE=1
- SR_SEL  in  5  `sr_sel_t` register select
- SR_WE  in  1  LDSR write strobe
- SR_WD  in  32  LDSR write data
- SR_RD  out  32  STSR read data (combinational)
- ALU_FL_WE  in  1  ALU flag update strobe
- ALU_FL  in  4  new `aluflags_t`
- PSW  out  32  current `psw_t`
- EXC_REQ  in  1  synchronous exception request
- EXC_CODE  in  16  exception code
- EXC_PC  in  32  PC to save for exception/NMI
- NMI_REQ  in  1  non-maskable interrupt request
- INT_REQ  in  1  maskable interrupt request (level-sensitive)
- INT_LEVEL  in  4  interrupt level
- INT_PC  in  32  PC to save for interrupt (next instruction)
- RETI  in  1  return-from-trap strobe
- EVT_ACK  out  1  one-cycle pulse: event accepted this cycle
- VEC_VALID  out  1  redirect PC valid
- VEC_PC  out  32  redirect target
- VEC_ACK  in  1  fetch took redirect
- FATAL  out  1  core halted on fatal exception

## Operation
- States: IDLE, VECT, HALT. RES forces VECT with VEC_PC=FFFF_FFF0, PSW=0000_8000 (NP=1), ECR=0000_FFF0, and all other registers 0. EVT_ACK=0 and FATAL=0 on reset.
- Events are considered only in IDLE. Priority: EXC_REQ > NMI_REQ > INT_REQ > RETI. The winner raises EVT_ACK. All others are ignored that cycle, and sources hold their requests.
- Exception with NP=1, or NMI with NP=1: go to HALT with FATAL=1 and no register writes.
- Exception with EP=1, NP=0: FEPC=EXC_PC, FEPSW=PSW, ECR.fecc=EXC_CODE, NP=1. Vector FFFF_FFD0.
- Exception with EP=0: EIPC=EXC_PC, EIPSW=PSW, ECR.eicc=EXC_CODE, EP=1. Vector FFFF_0000 | (code & FFF0).
- NMI with NP=0: FEPC=EXC_PC, FEPSW=PSW, fecc=FFD0, NP=1. Vector FFFF_FFD0.
- Interrupt is accepted iff ID=0, EP=0, NP=0 and INT_LEVEL >= PSW.i. On accept: EIPC=INT_PC, EIPSW=PSW, eicc=FE00|(level<<4), EP=1, and i=level+1, saturating at 15. Vector FFFF_FE00|(level<<4).
- Every accepted trap also sets ID=1 and AE=0.
- RETI: if NP=1, PSW=FEPSW and vector FEPC; else PSW=EIPSW and vector EIPC.
- LDSR write masks:
  - PSW: rfu bits forced 0.
  - EIPC/FEPC: bit0 forced 0.
  - ADTRE: bit0 forced 0.
  - CHCW: only ice stored.
  - ECR, PIR, TKCW: writes ignored.
- SR_RD for an unlisted select returns 0. PIR and TKCW read their parameters.
- ALU_FL_WE updates PSW.alu_fl. An LDSR to PSW in the same cycle wins. A trap or RETI in the same cycle wins over both.

## Timing
- SR_RD and PSW are combinational from registers. Writes are visible the cycle after the CE edge.
- Trap or RETI accepted in cycle t: registers update at the end of t, and VEC_VALID=1 with VEC_PC stable from t+1.
- VEC_VALID holds until VEC_ACK=1 with CE=1, then the state returns to IDLE. An event can be accepted the cycle after the ack.
- HALT is left only by RES. RES asserted mid-VECT or mid-HALT takes effect immediately (async).

## Test plan
- Reset, then VEC_ACK after 2 cycles -> VEC_PC=FFFF_FFF0 held until ack; PSW=0000_8000; ECR=0000_FFF0.
- Clear NP via LDSR PSW=0, then EXC_REQ code FF60 with EXC_PC=1234 -> EIPC=1234, eicc=FF60, EP=1, ID=1, VEC_PC=FFFF_FF60.
- While EP=1, EXC_REQ code FF80 -> FEPC saved, NP=1, VEC_PC=FFFF_FFD0. A further EXC_REQ -> FATAL=1, and registers are unchanged.
- PSW.i=5, INT_LEVEL=4 -> ignored. INT_LEVEL=7 -> accepted, i=8, VEC_PC=FFFF_FE70. Repeat with INT_LEVEL=15 -> i=15.
- RETI with EP=1, NP=0, EIPSW=0000_0003 -> PSW=0000_0003, VEC_PC=EIPC.
- Same-cycle ALU_FL_WE=1 (flags 1111) and LDSR PSW=0 -> alu_fl=0. Same-cycle EXC_REQ and INT_REQ -> only the exception is taken.

Source files
------------

// File: rtl/v810_sysreg.sv
// V810 system register file and exception sequencer.
// Serves LDSR/STSR, takes traps/RETI and hands fetch a redirect PC.
package v810_pkg;

  typedef enum logic [4:0] {
    SR_EIPC  = 5'd0,
    SR_EIPSW = 5'd1,
    SR_FEPC  = 5'd2,
    SR_FEPSW = 5'd3,
    SR_ECR   = 5'd4,
    SR_PSW   = 5'd5,
    SR_PIR   = 5'd6,
    SR_TKCW  = 5'd7,
    SR_CHCW  = 5'd24,
    SR_ADTRE = 5'd25
  } sr_sel_t;

  typedef struct packed {
    logic cy;
    logic ov;
    logic s;
    logic z;
  } aluflags_t;

  typedef struct packed {
    logic [11:0] rfu_hi;
    logic [3:0]  i;
    logic        np;
    logic        ep;
    logic        ae;
    logic        id;
    logic [1:0]  rfu_lo;
    logic [5:0]  fpu;
    aluflags_t   fl;
  } psw_t;

  localparam logic [31:0] PSW_MASK = 32'h000F_F3FF;

  typedef enum logic [1:0] {
    IDLE,
    VECT,
    HALT
  } state_t;

endpackage

import v810_pkg::*;

module v810_sysreg #(
  parameter logic [31:0] PIR_VALUE  = 32'h0000_8100,
  parameter logic [31:0] TKCW_VALUE = 32'h0000_00E0
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        CE,
  input  sr_sel_t     SR_SEL,
  input  logic        SR_WE,
  input  logic [31:0] SR_WD,
  output logic [31:0] SR_RD,
  input  logic        ALU_FL_WE,
  input  aluflags_t   ALU_FL,
  output psw_t        PSW,
  input  logic        EXC_REQ,
  input  logic [15:0] EXC_CODE,
  input  logic [31:0] EXC_PC,
  input  logic        NMI_REQ,
  input  logic        INT_REQ,
  input  logic [3:0]  INT_LEVEL,
  input  logic [31:0] INT_PC,
  input  logic        RETI,
  output logic        EVT_ACK,
  output logic        VEC_VALID,
  output logic [31:0] VEC_PC,
  input  logic        VEC_ACK,
  output logic        FATAL
);

  state_t      state, state_nx;
  psw_t        psw_q, psw_tr;
  logic [31:0] eipc, eipsw, fepc, fepsw;
  logic [31:0] ecr, adtre, vec_pc;
  logic        ice;

  logic idle, int_ok;
  logic go_exc, go_nmi, go_int, go_reti;
  logic fatal_evt, exc_fe, exc_ei, nmi_fe;
  logic [3:0]  lvl_inc;
  logic [15:0] int_code;

  assign idle    = CE && (state == IDLE);
  assign int_ok  = !psw_q.id && !psw_q.ep && !psw_q.np &&
                   (INT_LEVEL >= psw_q.i);
  assign go_exc  = idle && EXC_REQ;
  assign go_nmi  = idle && !EXC_REQ && NMI_REQ;
  assign go_int  = idle && !EXC_REQ && !NMI_REQ &&
                   INT_REQ && int_ok;
  assign go_reti = idle && !EXC_REQ && !NMI_REQ &&
                   !(INT_REQ && int_ok) && RETI;

  assign fatal_evt = (go_exc || go_nmi) && psw_q.np;
  assign exc_fe    = go_exc && !psw_q.np && psw_q.ep;
  assign exc_ei    = go_exc && !psw_q.np && !psw_q.ep;
  assign nmi_fe    = go_nmi && !psw_q.np;

  assign lvl_inc  = (INT_LEVEL == 4'hF) ? 4'hF
                                        : INT_LEVEL + 4'd1;
  assign int_code = {8'hFE, INT_LEVEL, 4'h0};

  // Common trap side effects on the saved-from PSW.
  always_comb begin
    psw_tr    = psw_q;
    psw_tr.id = 1'b1;
    psw_tr.ae = 1'b0;
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES)
      state <= VECT;
    else if (CE)
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (fatal_evt)
          state_nx = HALT;
        else if (go_exc || go_nmi || go_int || go_reti)
          state_nx = VECT;
      end
      VECT: if (VEC_ACK) state_nx = IDLE;
      HALT: state_nx = HALT;
      default: state_nx = VECT;
    endcase
  end

  always_comb begin
    EVT_ACK   = go_exc || go_nmi || go_int || go_reti;
    VEC_VALID = (state == VECT);
    FATAL     = (state == HALT);
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      psw_q  <= psw_t'(32'h0000_8000);
      ecr    <= 32'h0000_FFF0;
      vec_pc <= 32'hFFFF_FFF0;
      eipc   <= '0;
      eipsw  <= '0;
      fepc   <= '0;
      fepsw  <= '0;
      adtre  <= '0;
      ice    <= 1'b0;
    end else if (CE) begin
      unique case (1'b1)
        fatal_evt: ;
        exc_fe: begin
          fepc         <= EXC_PC;
          fepsw        <= psw_q;
          ecr[31:16]   <= EXC_CODE;
          psw_q        <= psw_tr;
          psw_q.np     <= 1'b1;
          vec_pc       <= 32'hFFFF_FFD0;
        end
        exc_ei: begin
          eipc         <= EXC_PC;
          eipsw        <= psw_q;
          ecr[15:0]    <= EXC_CODE;
          psw_q        <= psw_tr;
          psw_q.ep     <= 1'b1;
          vec_pc       <= {16'hFFFF, EXC_CODE & 16'hFFF0};
        end
        nmi_fe: begin
          fepc         <= EXC_PC;
          fepsw        <= psw_q;
          ecr[31:16]   <= 16'hFFD0;
          psw_q        <= psw_tr;
          psw_q.np     <= 1'b1;
          vec_pc       <= 32'hFFFF_FFD0;
        end
        go_int: begin
          eipc         <= INT_PC;
          eipsw        <= psw_q;
          ecr[15:0]    <= int_code;
          psw_q        <= psw_tr;
          psw_q.ep     <= 1'b1;
          psw_q.i      <= lvl_inc;
          vec_pc       <= {16'hFFFF, int_code};
        end
        go_reti: begin
          psw_q  <= psw_t'((psw_q.np ? fepsw : eipsw) & PSW_MASK);
          vec_pc <= psw_q.np ? fepc : eipc;
        end
        default: begin
          if (ALU_FL_WE)
            psw_q.fl <= ALU_FL;
          // An LDSR to PSW lands after the flag update and overrides it.
          if (SR_WE) begin
            case (SR_SEL)
              SR_EIPC:  eipc  <= {SR_WD[31:1], 1'b0};
              SR_EIPSW: eipsw <= SR_WD;
              SR_FEPC:  fepc  <= {SR_WD[31:1], 1'b0};
              SR_FEPSW: fepsw <= SR_WD;
              SR_PSW:   psw_q <= psw_t'(SR_WD & PSW_MASK);
              SR_CHCW:  ice   <= SR_WD[1];
              SR_ADTRE: adtre <= {SR_WD[31:1], 1'b0};
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_comb begin
    case (SR_SEL)
      SR_EIPC:  SR_RD = eipc;
      SR_EIPSW: SR_RD = eipsw;
      SR_FEPC:  SR_RD = fepc;
      SR_FEPSW: SR_RD = fepsw;
      SR_ECR:   SR_RD = ecr;
      SR_PSW:   SR_RD = psw_q;
      SR_PIR:   SR_RD = PIR_VALUE;
      SR_TKCW:  SR_RD = TKCW_VALUE;
      SR_CHCW:  SR_RD = {30'b0, ice, 1'b0};
      SR_ADTRE: SR_RD = adtre;
      default:  SR_RD = '0;
    endcase
  end

  assign PSW    = psw_q;
  assign VEC_PC = vec_pc;

endmodule
